// File: rtl/umi_regbank_pkg.sv
// rtl/umi_regbank_pkg.sv - register map constants and access-size helper for umi_regbank
package umi_regbank_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_IRQEN  = 2;
  localparam int REG_CYCLE  = 3;
  localparam int REG_GP0    = 4;

  // log2 of the access width in bytes, clamped to the register width
  function automatic int access_log2(input logic [3:0] size, input int bl);
    return (int'(size) > bl) ? bl : int'(size);
  endfunction

endpackage

// File: rtl/umi_regbank_if.sv
// rtl/umi_regbank_if.sv - UMI register-strobe bus between the UMI interface and the register bank
interface umi_regbank_if #(
  parameter int AW = 64,
  parameter int DW = 64
);

  logic [AW-1:0]   reg_addr;
  logic            reg_write;
  logic            reg_read;
  logic [7:0]      reg_cmd;
  logic [3:0]      reg_size;
  logic [4*DW-1:0] reg_wrdata;
  logic [DW-1:0]   reg_rddata;

  modport master (
    output reg_addr,
    output reg_write,
    output reg_read,
    output reg_cmd,
    output reg_size,
    output reg_wrdata,
    input  reg_rddata
  );

  modport slave (
    input  reg_addr,
    input  reg_write,
    input  reg_read,
    input  reg_cmd,
    input  reg_size,
    input  reg_wrdata,
    output reg_rddata
  );

endinterface

// File: rtl/umi_regbank_bytemask.sv
// rtl/umi_regbank_bytemask.sv - byte strobe for bytes off..off+N-1, clipped at the top of the word
module umi_regbank_bytemask
  import umi_regbank_pkg::*;
#(
  parameter int DW = 64,
  localparam int NB = DW / 8,
  localparam int BL = $clog2(NB)
) (
  input  logic [3:0]    size,
  input  logic [BL-1:0] off,
  output logic [NB-1:0] strb
);

  int nbytes;
  int lo;

  always_comb begin
    nbytes = 1 << access_log2(size, BL);
    lo     = int'(off);
    strb   = '0;
    for (int b = 0; b < NB; b++) begin
      strb[b] = (b >= lo) && (b < lo + nbytes);
    end
  end

endmodule

// File: rtl/umi_regbank.sv
// rtl/umi_regbank.sv - CTRL/STATUS/IRQEN/CYCLE/GP register bank behind the UMI register strobes
module umi_regbank
  import umi_regbank_pkg::*;
#(
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int NREG = 8
) (
  input  logic                   clk,
  input  logic                   nreset,
  umi_regbank_if.slave           bus,
  output logic [DW-1:0]          ctrl,
  input  logic [DW-1:0]          event_in,
  output logic                   irq,
  output logic [(NREG-4)*DW-1:0] gpreg
);

  localparam int NB = DW / 8;
  localparam int BL = $clog2(NB);
  localparam int IW = $clog2(NREG);

  logic [BL-1:0] off;
  logic [IW-1:0] idx;
  logic [BL+2:0] sh;
  logic [NB-1:0] strb;
  logic [NB-1:0] rstrb;
  logic [DW-1:0] wmask;
  logic [DW-1:0] rmask;
  logic [DW-1:0] wdata;
  logic [DW-1:0] clr;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] nxt  [NREG];
  logic [DW-1:0] rddata_q;
  logic [DW-1:0] rd_next;
  logic          irq_next;
  logic          unused_bits;

  assign off   = bus.reg_addr[BL-1:0];
  assign idx   = bus.reg_addr[BL+IW-1:BL];
  assign sh    = {off, 3'b000};
  assign unused_bits = ^{bus.reg_cmd, bus.reg_wrdata[4*DW-1:DW], bus.reg_addr[AW-1:BL+IW]};

  umi_regbank_bytemask #(.DW(DW)) u_bytemask (
    .size (bus.reg_size),
    .off  (off),
    .strb (strb)
  );

  // Read strobe is the write strobe moved down to byte 0, so it is already clipped.
  assign rstrb = strb >> off;
  assign wdata = bus.reg_wrdata[DW-1:0] << sh;

  always_comb begin
    wmask = '0;
    rmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{strb[b]}};
      rmask[8*b +: 8] = {8{rstrb[b]}};
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      nxt[i] = regs[i];
    end
    nxt[REG_CYCLE] = regs[REG_CYCLE] + DW'(1);
    for (int i = 0; i < NREG; i++) begin
      if (bus.reg_write && idx == IW'(i) && i != REG_STATUS) begin
        nxt[i] = (nxt[i] & ~wmask) | (wdata & wmask);
      end
    end
    clr = (bus.reg_write && idx == IW'(REG_STATUS)) ? (wmask & wdata) : '0;
    nxt[REG_STATUS] = (regs[REG_STATUS] & ~clr) | event_in;
    irq_next = |(nxt[REG_STATUS] & nxt[REG_IRQEN]);
    // Reads see the pre-write, pre-increment register contents.
    rd_next = bus.reg_read ? ((regs[idx] >> sh) & rmask) : rddata_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      rddata_q <= '0;
      irq      <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= nxt[i];
      end
      rddata_q <= rd_next;
      irq      <= irq_next;
    end
  end

  assign bus.reg_rddata = rddata_q;
  assign ctrl           = regs[REG_CTRL];

  for (genvar g = REG_GP0; g < NREG; g++) begin : g_gp
    assign gpreg[(g-REG_GP0)*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_umi_regbank.sv
// tb/tb_umi_regbank.sv - directed scoreboard bench for umi_regbank
module tb_umi_regbank;

  logic         clk = 1'b0;
  logic         nreset;
  logic [63:0]  event_in;
  logic [63:0]  ctrl;
  logic         irq;
  logic [255:0] gpreg;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] expq[$];
  string       nameq[$];

  always #5 clk = ~clk;

  umi_regbank_if #(.AW(64), .DW(64)) bus ();

  umi_regbank #(.AW(64), .DW(64), .NREG(8)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .bus      (bus.slave),
    .ctrl     (ctrl),
    .event_in (event_in),
    .irq      (irq),
    .gpreg    (gpreg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // monitor: every accepted read strobe yields one rddata one cycle later
  initial begin
    logic fire;
    forever begin
      @(posedge clk);
      fire = bus.reg_read && nreset;
      #1;
      if (fire) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got %h required no read", bus.reg_rddata);
        end else begin
          chk(nameq.pop_front(), bus.reg_rddata, expq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic idle();
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
    bus.reg_addr   = a;
    bus.reg_size   = s;
    bus.reg_wrdata = {192'h0, d};
    bus.reg_write  = 1'b1;
    @(negedge clk);
    bus.reg_write  = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input logic [3:0] s, input logic [63:0] exp,
                    input string name);
    bus.reg_addr = a;
    bus.reg_size = s;
    bus.reg_read = 1'b1;
    expq.push_back(exp);
    nameq.push_back(name);
    @(negedge clk);
    bus.reg_read = 1'b0;
  endtask

  task automatic rw(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d,
                    input logic [63:0] exp, input string name);
    bus.reg_wrdata = {192'h0, d};
    bus.reg_write  = 1'b1;
    rd(a, s, exp, name);
    bus.reg_write  = 1'b0;
  endtask

  initial begin
    nreset         = 1'b0;
    event_in       = '0;
    bus.reg_addr   = '0;
    bus.reg_write  = 1'b0;
    bus.reg_read   = 1'b0;
    bus.reg_cmd    = 8'h0;
    bus.reg_size   = 4'h3;
    bus.reg_wrdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rddata", bus.reg_rddata, 64'h0);
    chk("rst_ctrl", ctrl, 64'h0);
    chk("rst_irq", {63'h0, irq}, 64'h0);
    chk("rst_gp0", gpreg[63:0], 64'h0);
    nreset = 1'b1;

    rd(64'h00, 3, 64'h0, "rd_ctrl0");
    rd(64'h08, 3, 64'h0, "rd_status0");
    rd(64'h10, 3, 64'h0, "rd_irqen0");
    rd(64'h20, 3, 64'h0, "rd_gp0_0");
    chk("irq_idle", {63'h0, irq}, 64'h0);

    wr(64'h00, 3, 64'h1122334455667788);
    chk("ctrl_wr", ctrl, 64'h1122334455667788);
    rd(64'h00, 3, 64'h1122334455667788, "ctrl_rd");

    wr(64'h23, 0, 64'hAB);
    chk("gp0_byte", gpreg[63:0], 64'h00000000AB000000);
    rd(64'h23, 1, 64'h00AB, "gp0_half");

    wr(64'h10, 3, 64'h4);
    event_in = 64'h5;
    @(negedge clk);
    event_in = 64'h0;
    chk("irq_set", {63'h0, irq}, 64'h1);
    rd(64'h08, 3, 64'h5, "status_set");

    event_in = 64'h4;
    wr(64'h08, 3, 64'h4);
    event_in = 64'h0;
    chk("irq_setwins", {63'h0, irq}, 64'h1);
    rd(64'h08, 3, 64'h5, "status_setwins");

    wr(64'h08, 3, 64'h4);
    chk("irq_clr", {63'h0, irq}, 64'h0);
    rd(64'h08, 3, 64'h1, "status_clr");

    wr(64'h18, 3, 64'hFFFFFFFFFFFFFFFE);
    idle();
    rd(64'h18, 3, 64'hFFFFFFFFFFFFFFFF, "cycle_max");
    rd(64'h18, 3, 64'h0, "cycle_wrap");

    wr(64'h28, 3, 64'h0102030405060708);
    wr(64'h2E, 3, 64'hCCDD);
    chk("gp1_trunc", gpreg[127:64], 64'hCCDD030405060708);
    rd(64'h28, 3, 64'hCCDD030405060708, "gp1_rd");
    rd(64'h2E, 3, 64'hCCDD, "gp1_off6");

    bus.reg_addr = 64'h00;
    bus.reg_size = 4'h3;
    rw(64'h00, 3, 64'hDEAD, 64'h1122334455667788, "rw_prewrite");
    chk("rw_ctrl", ctrl, 64'hDEAD);

    event_in = 64'h4;
    @(negedge clk);
    event_in = 64'h0;
    chk("irq_prereset", {63'h0, irq}, 64'h1);

    bus.reg_addr   = 64'h00;
    bus.reg_size   = 4'h3;
    bus.reg_wrdata = {192'h0, 64'h5555};
    bus.reg_write  = 1'b1;
    bus.reg_read   = 1'b1;
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_rddata", bus.reg_rddata, 64'h0);
    chk("arst_ctrl", ctrl, 64'h0);
    chk("arst_irq", {63'h0, irq}, 64'h0);
    chk("arst_gp0", gpreg[63:0], 64'h0);
    chk("arst_gp1", gpreg[127:64], 64'h0);
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    rd(64'h18, 3, 64'h0, "cycle_restart0");
    rd(64'h18, 3, 64'h1, "cycle_restart1");
    chk("ctrl_aborted", ctrl, 64'h0);

    repeat (3) idle();
    chk("queue_drained", 64'(expq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/umi_regbank.md
Name: umi_regbank

Overview:
- Register bank sitting directly downstream of the UMI register interface; consumes its reg_* write/read strobes and returns reg_rddata one cycle after a read strobe.
- Provides a control register, a sticky W1C status register with interrupt, an interrupt enable, a free-running cycle counter and NREG-4 general-purpose registers exported to the core.
- Supports sub-word (byte/half/word) accesses via reg_size and the low address bits.

Parameters:
- AW, 64, address width.
- DW, 64, register/data width; power of two, 32 or 64.
- NREG, 8, number of registers; power of two, minimum 4.

Ports:
- clk  input  1  clock
- nreset  input  1  async active-low reset
- reg_addr  input  AW  byte address of access
- reg_write  input  1  write strobe, one cycle per access
- reg_read  input  1  read strobe, one cycle per access
- reg_cmd  input  8  UMI command; ignored (no atomics)
- reg_size  input  4  log2 of access bytes
- reg_wrdata  input  4*DW  write data, LSB-aligned; only [DW-1:0] used
- reg_rddata  output  DW  read data, LSB-aligned, registered
- ctrl  output  DW  CTRL register value
- event_in  input  DW  per-bit event pulses into STATUS
- irq  output  1  registered interrupt
- gpreg  output  (NREG-4)*DW  general registers, index 4 at LSB

Behaviour:
- Interface: one clock clk; reset nreset is asynchronous, active-low.
- Addressing: BL = log2(DW/8); OFF = reg_addr[BL-1:0]; IDX = reg_addr[BL+log2(NREG)-1:BL]; higher address bits are ignored (group decode is upstream).
- Map: 0 CTRL (RW), 1 STATUS (W1C, sticky), 2 IRQEN (RW), 3 CYCLE (RW, increments every cycle), 4..NREG-1 GP (RW).
- Access bytes: N = 2^min(reg_size, BL).
- Byte strobe: bytes OFF..OFF+N-1 within the word. Bytes beyond DW/8 are dropped; misaligned writes are truncated and never wrap.
- Write data: reg_wrdata[DW-1:0] << 8*OFF, merged under the byte strobe.
- Write: the register updates on the clock edge that samples reg_write.
- STATUS: next = (status & ~(wmask & wdata)) | event_in. On a same-cycle clear and event, the event wins.
- CYCLE: wraps 2^DW-1 -> 0. On a same-cycle write and increment, the write wins for the strobed bytes; unstrobed bytes take the incremented value.
- Read: on reg_read, reg_rddata <= selected register >> 8*OFF, masked to N bytes (upper bytes zero). reg_rddata then holds until the next reg_read.
- Read latency: exactly 1 cycle.
- CYCLE read returns the pre-increment value sampled at the strobe edge.
- reg_read and reg_write asserted together: the write is performed and reg_rddata is updated from the pre-write value.
- irq <= |(STATUS_next & IRQEN_next), registered, so it follows the register update by 0 extra cycles.
- Reset values: all registers, reg_rddata, ctrl, gpreg and irq are 0; CYCLE restarts at 0.
- Reset asserted mid-access aborts the access. The first edge after release counts CYCLE from 0 -> 1.
- No state machine beyond the register flops; reg_cmd and reg_wrdata[4*DW-1:DW] are unused.

Decomposition:
- Shared package (umi_regbank_pkg): register index constants REG_CTRL=0, REG_STATUS=1, REG_IRQEN=2, REG_CYCLE=3, REG_GP0=4.
- One sub-module, umi_regbank_bytemask: (size, off) -> DW/8 byte strobe; reused by the write merge and the read mask.

Test Plan:
- Reset, then read IDX 0,1,2,4 (size 3) -> reg_rddata = 0 one cycle after each strobe; irq = 0.
- Write 0x1122334455667788 to CTRL, size 3 -> ctrl equals the value the next cycle; readback matches.
- Byte write 0xAB, size 0, to addr 0x23 (GP0, OFF 3) -> GP0 = 0x00000000AB000000.
- Read size 1 at addr 0x23 -> reg_rddata = 0x00AB.
- Pulse event_in = 0x5 with IRQEN = 0x4 -> STATUS = 0x5 and irq = 1.
- Write 0x4 to STATUS while event_in = 0x4 -> STATUS stays 0x5 (set wins).
- Write 0x4 to STATUS with event_in = 0 -> STATUS = 0x1 and irq = 0.
- Write CYCLE = 0xFFFFFFFFFFFFFFFE -> reads 0xFFFFFFFFFFFFFFFF, then 0 after wrap.
- Write size 3 at OFF 6 with data 0xCCDD -> only bytes 6-7 are written (truncation).
- Assert nreset mid-sequence -> all outputs 0 asynchronously.
